// File: rtl/ex_operand_stage_if.sv
// ID/EX operand stage bus: decode fields, forwarding sources and ALU-facing outputs.
// Latency: n/a (signal bundle only).
// Backpressure: hold freezes the stage, stallOut asks fetch/decode to repeat.
// Ports: master = upstream driver (decode, forward sources, hold/flush), slave = the stage.
interface ex_operand_stage_if #(
    parameter int WIDTH = 32
);
    logic             hold;
    logic             flush;
    logic             idValid;
    logic [4:0]       idRs1;
    logic [4:0]       idRs2;
    logic [4:0]       idRd;
    logic [WIDTH-1:0] idRs1Data;
    logic [WIDTH-1:0] idRs2Data;
    logic [WIDTH-1:0] idImm;
    logic [WIDTH-1:0] idPc;
    logic [3:0]       idFunc;
    logic [2:0]       idAluOp;
    logic             idAluSrc;
    logic             idRegWrite;
    logic             idMemRead;
    logic             idMemWrite;
    logic             idBranch;
    logic             exMemRegWrite;
    logic [4:0]       exMemRd;
    logic [WIDTH-1:0] exMemResult;
    logic             memWbRegWrite;
    logic [4:0]       memWbRd;
    logic [WIDTH-1:0] memWbResult;
    logic [WIDTH-1:0] dataA;
    logic [WIDTH-1:0] dataB;
    logic [WIDTH-1:0] storeData;
    logic [3:0]       func;
    logic [2:0]       aluOp;
    logic             exValid;
    logic             exRegWrite;
    logic             exMemRead;
    logic             exMemWrite;
    logic             exBranch;
    logic [4:0]       exRd;
    logic [WIDTH-1:0] exPc;
    logic             stallOut;

    modport master (
        output hold, flush, idValid, idRs1, idRs2, idRd, idRs1Data, idRs2Data,
               idImm, idPc, idFunc, idAluOp, idAluSrc, idRegWrite, idMemRead,
               idMemWrite, idBranch, exMemRegWrite, exMemRd, exMemResult,
               memWbRegWrite, memWbRd, memWbResult,
        input  dataA, dataB, storeData, func, aluOp, exValid, exRegWrite,
               exMemRead, exMemWrite, exBranch, exRd, exPc, stallOut
    );

    modport slave (
        input  hold, flush, idValid, idRs1, idRs2, idRd, idRs1Data, idRs2Data,
               idImm, idPc, idFunc, idAluOp, idAluSrc, idRegWrite, idMemRead,
               idMemWrite, idBranch, exMemRegWrite, exMemRd, exMemResult,
               memWbRegWrite, memWbRd, memWbResult,
        output dataA, dataB, storeData, func, aluOp, exValid, exRegWrite,
               exMemRead, exMemWrite, exBranch, exRd, exPc, stallOut
    );
endinterface

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding and load-use bubble insertion.
// Latency: 1 cycle id* -> ex*; forwarding and stallOut are combinational.
// Backpressure: hold freezes the register (operands refreshed); stallOut stalls decode one cycle.
// Ports: clock, reset_n (async active-low), bus (ex_operand_stage_if.slave).
module ex_operand_stage #(
    parameter int WIDTH = 32
) (
    input  logic               clock,
    input  logic               reset_n,
    ex_operand_stage_if.slave  bus
);

    typedef struct packed {
        logic             valid;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [4:0]       rd;
        logic [WIDTH-1:0] rs1_val;
        logic [WIDTH-1:0] rs2_val;
        logic [WIDTH-1:0] imm;
        logic [WIDTH-1:0] pc;
        logic [3:0]       func;
        logic [2:0]       alu_op;
        logic             alu_src;
        logic             reg_write;
        logic             mem_read;
        logic             mem_write;
        logic             branch;
    } stage_t;

    stage_t           stage_q;
    stage_t           stage_d;
    logic [WIDTH-1:0] fwd_rs1;
    logic [WIDTH-1:0] fwd_rs2;
    logic             stall;

    // EX/MEM beats MEM/WB because it carries the younger write; x0 is hardwired zero.
    function automatic logic [WIDTH-1:0] fwd_sel(
        input logic [4:0]       r,
        input logic [WIDTH-1:0] stored,
        input logic             em_we,
        input logic [4:0]       em_rd,
        input logic [WIDTH-1:0] em_res,
        input logic             mw_we,
        input logic [4:0]       mw_rd,
        input logic [WIDTH-1:0] mw_res
    );
        if (em_we && (em_rd != 5'd0) && (em_rd == r)) begin
            return em_res;
        end else if (mw_we && (mw_rd != 5'd0) && (mw_rd == r)) begin
            return mw_res;
        end
        return stored;
    endfunction

    always_comb begin
        fwd_rs1 = fwd_sel(stage_q.rs1, stage_q.rs1_val, bus.exMemRegWrite, bus.exMemRd,
                          bus.exMemResult, bus.memWbRegWrite, bus.memWbRd, bus.memWbResult);
        fwd_rs2 = fwd_sel(stage_q.rs2, stage_q.rs2_val, bus.exMemRegWrite, bus.exMemRd,
                          bus.exMemResult, bus.memWbRegWrite, bus.memWbRd, bus.memWbResult);
    end

    // rs2 is compared even when the decoded op has no rs2: a harmless extra stall.
    assign stall = stage_q.valid & stage_q.mem_read & (stage_q.rd != 5'd0) & bus.idValid &
                   ((stage_q.rd == bus.idRs1) | (stage_q.rd == bus.idRs2)) & ~bus.flush;

    always_comb begin
        stage_d = stage_q;
        if (bus.flush || (!bus.hold && stall)) begin
            stage_d.valid     = 1'b0;
            stage_d.reg_write = 1'b0;
            stage_d.mem_read  = 1'b0;
            stage_d.mem_write = 1'b0;
            stage_d.branch    = 1'b0;
        end else if (bus.hold) begin
            // Capture forwarded operands so a producer retiring during the hold is not lost.
            stage_d.rs1_val = fwd_rs1;
            stage_d.rs2_val = fwd_rs2;
        end else begin
            stage_d.valid     = bus.idValid;
            stage_d.rs1       = bus.idRs1;
            stage_d.rs2       = bus.idRs2;
            stage_d.rd        = bus.idRd;
            stage_d.rs1_val   = bus.idRs1Data;
            stage_d.rs2_val   = bus.idRs2Data;
            stage_d.imm       = bus.idImm;
            stage_d.pc        = bus.idPc;
            stage_d.func      = bus.idFunc;
            stage_d.alu_op    = bus.idAluOp;
            stage_d.alu_src   = bus.idAluSrc;
            stage_d.reg_write = bus.idRegWrite;
            stage_d.mem_read  = bus.idMemRead;
            stage_d.mem_write = bus.idMemWrite;
            stage_d.branch    = bus.idBranch;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign bus.dataA      = fwd_rs1;
    assign bus.storeData  = fwd_rs2;
    assign bus.dataB      = stage_q.alu_src ? stage_q.imm : fwd_rs2;
    assign bus.func       = stage_q.func;
    assign bus.aluOp      = stage_q.alu_op;
    assign bus.exValid    = stage_q.valid;
    assign bus.exRegWrite = stage_q.valid & stage_q.reg_write;
    assign bus.exMemRead  = stage_q.valid & stage_q.mem_read;
    assign bus.exMemWrite = stage_q.valid & stage_q.mem_write;
    assign bus.exBranch   = stage_q.valid & stage_q.branch;
    assign bus.exRd       = stage_q.rd;
    assign bus.exPc       = stage_q.pc;
    assign bus.stallOut   = stall;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Self-checking bench for ex_operand_stage: directed instruction sequences,
// a reference model of the instruction held in EX, and per-cycle comparison.
module tb_ex_operand_stage;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    logic cmp_en  = 1'b0;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clock = ~clock;

    ex_operand_stage_if #(.WIDTH(32)) bus ();

    ex_operand_stage #(.WIDTH(32)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // The instruction the model believes is sitting in EX.
    typedef struct {
        logic        v;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] a, b, imm, pc;
        logic [3:0]  fn;
        logic [2:0]  op;
        logic        src, rw, mr, mw, br;
    } minst_t;

    minst_t m;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    endtask

    // Value an instruction reading register r sees: newest in-flight write wins.
    function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] stored);
        if (r == 0) return stored;
        if (bus.exMemRegWrite && bus.exMemRd == r) return bus.exMemResult;
        if (bus.memWbRegWrite && bus.memWbRd == r) return bus.memWbResult;
        return stored;
    endfunction

    function automatic logic load_use();
        return m.v && m.mr && m.rd != 0 && bus.idValid &&
               (m.rd == bus.idRs1 || m.rd == bus.idRs2) && !bus.flush;
    endfunction

    function automatic minst_t empty_inst();
        minst_t z;
        z = '{v:0, rs1:0, rs2:0, rd:0, a:0, b:0, imm:0, pc:0, fn:0, op:0,
              src:0, rw:0, mr:0, mw:0, br:0};
        return z;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m = empty_inst();
        end else if (bus.flush || (!bus.hold && load_use())) begin
            // Squashed or bubbled: nothing valid, nothing with side effects.
            m.v = 0; m.rw = 0; m.mr = 0; m.mw = 0; m.br = 0;
        end else if (bus.hold) begin
            m.a = fwd(m.rs1, m.a);
            m.b = fwd(m.rs2, m.b);
        end else begin
            m = '{v:bus.idValid, rs1:bus.idRs1, rs2:bus.idRs2, rd:bus.idRd,
                  a:bus.idRs1Data, b:bus.idRs2Data, imm:bus.idImm, pc:bus.idPc,
                  fn:bus.idFunc, op:bus.idAluOp, src:bus.idAluSrc, rw:bus.idRegWrite,
                  mr:bus.idMemRead, mw:bus.idMemWrite, br:bus.idBranch};
        end
    end

    always @(negedge clock) begin
        if (cmp_en) begin
            chk("m_dataA",      bus.dataA,             fwd(m.rs1, m.a));
            chk("m_dataB",      bus.dataB,             m.src ? m.imm : fwd(m.rs2, m.b));
            chk("m_storeData",  bus.storeData,         fwd(m.rs2, m.b));
            chk("m_func",       32'(bus.func),         32'(m.fn));
            chk("m_aluOp",      32'(bus.aluOp),        32'(m.op));
            chk("m_exValid",    32'(bus.exValid),      32'(m.v));
            chk("m_exRegWrite", 32'(bus.exRegWrite),   32'(m.v & m.rw));
            chk("m_exMemRead",  32'(bus.exMemRead),    32'(m.v & m.mr));
            chk("m_exMemWrite", 32'(bus.exMemWrite),   32'(m.v & m.mw));
            chk("m_exBranch",   32'(bus.exBranch),     32'(m.v & m.br));
            chk("m_exRd",       32'(bus.exRd),         32'(m.rd));
            chk("m_exPc",       bus.exPc,              m.pc);
            chk("m_stallOut",   32'(bus.stallOut),     32'(load_use()));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.hold = 0; bus.flush = 0; bus.idValid = 0;
        bus.idRs1 = 0; bus.idRs2 = 0; bus.idRd = 0;
        bus.idRs1Data = 0; bus.idRs2Data = 0; bus.idImm = 0; bus.idPc = 0;
        bus.idFunc = 0; bus.idAluOp = 0; bus.idAluSrc = 0;
        bus.idRegWrite = 0; bus.idMemRead = 0; bus.idMemWrite = 0; bus.idBranch = 0;
        bus.exMemRegWrite = 0; bus.exMemRd = 0; bus.exMemResult = 0;
        bus.memWbRegWrite = 0; bus.memWbRd = 0; bus.memWbResult = 0;
    endtask

    task automatic instr(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] imm, input logic [31:0] pc,
                         input logic [3:0] fn, input logic [2:0] op, input logic src,
                         input logic rw, input logic mr, input logic mw, input logic br);
        bus.idValid = 1; bus.idRs1 = rs1; bus.idRs2 = rs2; bus.idRd = rd;
        bus.idRs1Data = d1; bus.idRs2Data = d2; bus.idImm = imm; bus.idPc = pc;
        bus.idFunc = fn; bus.idAluOp = op; bus.idAluSrc = src;
        bus.idRegWrite = rw; bus.idMemRead = mr; bus.idMemWrite = mw; bus.idBranch = br;
    endtask

    task automatic lw_x5();
        instr(5'd2, 5'd0, 5'd5, 32'h100, 32'h0, 32'h4, 32'h40, 4'h2, 3'b000, 1, 1, 1, 0, 0);
    endtask

    task automatic add_x6_x5_x1();
        instr(5'd5, 5'd1, 5'd6, 32'h0, 32'h9, 32'h0, 32'h44, 4'h0, 3'b010, 0, 1, 0, 0, 0);
    endtask

    initial begin
        // Reset with garbage on every input: all outputs must read 0.
        bus.hold = 1'($urandom); bus.flush = 1'($urandom); bus.idValid = 1'($urandom);
        bus.idRs1 = 5'($urandom); bus.idRs2 = 5'($urandom); bus.idRd = 5'($urandom);
        bus.idRs1Data = $urandom; bus.idRs2Data = $urandom; bus.idImm = $urandom;
        bus.idPc = $urandom; bus.idFunc = 4'($urandom); bus.idAluOp = 3'($urandom);
        bus.idAluSrc = 1'($urandom); bus.idRegWrite = 1'($urandom);
        bus.idMemRead = 1'($urandom); bus.idMemWrite = 1'($urandom);
        bus.idBranch = 1'($urandom);
        bus.exMemRegWrite = 1'($urandom); bus.exMemRd = 5'($urandom);
        bus.exMemResult = $urandom; bus.memWbRegWrite = 1'($urandom);
        bus.memWbRd = 5'($urandom); bus.memWbResult = $urandom;
        tick();
        cmp_en = 1;
        chk("rst_dataA", bus.dataA, 32'h0);
        chk("rst_dataB", bus.dataB, 32'h0);
        chk("rst_storeData", bus.storeData, 32'h0);
        chk("rst_exValid", 32'(bus.exValid), 32'h0);
        chk("rst_exRegWrite", 32'(bus.exRegWrite), 32'h0);
        chk("rst_exPc", bus.exPc, 32'h0);
        chk("rst_stallOut", 32'(bus.stallOut), 32'h0);
        tick();
        idle();
        reset_n = 1;
        tick();

        // add x3,x1,x2 with rs1=5, rs2=7.
        instr(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'h0, 32'h10, 4'h0, 3'b010, 0, 1, 0, 0, 0);
        tick();
        idle();
        #1;
        chk("add_dataA", bus.dataA, 32'd5);
        chk("add_dataB", bus.dataB, 32'd7);
        chk("add_exRd", 32'(bus.exRd), 32'd3);
        chk("add_exRegWrite", 32'(bus.exRegWrite), 32'd1);

        // Forwarding priority on rs1=4 (stored 1).
        instr(5'd4, 5'd0, 5'd9, 32'd1, 32'd0, 32'h0, 32'h14, 4'h0, 3'b000, 0, 1, 0, 0, 0);
        tick();
        idle();
        bus.exMemRegWrite = 1; bus.exMemRd = 5'd4; bus.exMemResult = 32'h10;
        bus.memWbRegWrite = 1; bus.memWbRd = 5'd4; bus.memWbResult = 32'h20;
        #1;
        chk("fwd_exmem_prio", bus.dataA, 32'h10);
        bus.exMemRegWrite = 0;
        #1;
        chk("fwd_memwb", bus.dataA, 32'h20);
        instr(5'd0, 5'd0, 5'd9, 32'h33, 32'd0, 32'h0, 32'h18, 4'h0, 3'b000, 0, 1, 0, 0, 0);
        bus.exMemRegWrite = 1; bus.exMemRd = 5'd0; bus.memWbRd = 5'd0;
        tick();
        #1;
        chk("fwd_x0_never", bus.dataA, 32'h33);
        idle();

        // Load-use: lw x5 then add x6,x5,x1.
        lw_x5();
        tick();
        add_x6_x5_x1();
        #1;
        chk("lu_stall", 32'(bus.stallOut), 32'd1);
        tick();
        #1;
        chk("lu_bubble_valid", 32'(bus.exValid), 32'd0);
        chk("lu_bubble_rw", 32'(bus.exRegWrite), 32'd0);
        chk("lu_bubble_mr", 32'(bus.exMemRead), 32'd0);
        chk("lu_stall_1cyc", 32'(bus.stallOut), 32'd0);
        tick();
        #1;
        chk("lu_add_valid", 32'(bus.exValid), 32'd1);
        chk("lu_add_rd", 32'(bus.exRd), 32'd6);
        chk("lu_no_stall", 32'(bus.stallOut), 32'd0);
        idle();

        // Flush during a load-use.
        lw_x5();
        tick();
        add_x6_x5_x1();
        bus.flush = 1;
        #1;
        chk("fl_stall_masked", 32'(bus.stallOut), 32'd0);
        tick();
        idle();
        #1;
        chk("fl_valid", 32'(bus.exValid), 32'd0);
        chk("fl_rw", 32'(bus.exRegWrite), 32'd0);

        // Hold refresh: rs2=7 forwarded 0xAB, producer leaves during the hold.
        instr(5'd3, 5'd7, 5'd0, 32'h1000, 32'h55, 32'h8, 32'h50, 4'h2, 3'b000, 1, 0, 0, 1, 0);
        tick();
        idle();
        bus.exMemRegWrite = 1; bus.exMemRd = 5'd7; bus.exMemResult = 32'hAB;
        #1;
        chk("hold_pre", bus.storeData, 32'hAB);
        bus.hold = 1;
        tick();
        bus.exMemRegWrite = 0;
        #1;
        chk("hold_c1", bus.storeData, 32'hAB);
        tick();
        #1;
        chk("hold_c2", bus.storeData, 32'hAB);
        tick();
        bus.hold = 0;
        #1;
        chk("hold_after", bus.storeData, 32'hAB);
        chk("hold_kept_pc", bus.exPc, 32'h50);

        // Immediate select with rs2 forwarding active.
        instr(5'd0, 5'd9, 5'd10, 32'h0, 32'h1, 32'hFFFF_FFFC, 32'h60, 4'h0, 3'b000, 1, 1, 0, 0, 0);
        tick();
        idle();
        bus.memWbRegWrite = 1; bus.memWbRd = 5'd9; bus.memWbResult = 32'h77;
        #1;
        chk("imm_dataB", bus.dataB, 32'hFFFF_FFFC);
        chk("imm_storeData", bus.storeData, 32'h77);

        // Branch instruction, then async reset mid-cycle.
        idle();
        instr(5'd1, 5'd2, 5'd0, 32'h3, 32'h3, 32'h20, 32'h70, 4'h0, 3'b001, 0, 0, 0, 0, 1);
        tick();
        idle();
        #1;
        chk("br_exBranch", 32'(bus.exBranch), 32'd1);
        reset_n = 0;
        #1;
        chk("arst_valid", 32'(bus.exValid), 32'd0);
        chk("arst_branch", 32'(bus.exBranch), 32'd0);
        chk("arst_pc", bus.exPc, 32'h0);
        chk("arst_dataA", bus.dataA, 32'h0);
        tick();
        reset_n = 1;
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
